line_buf_fifo: RTL

Line-buffer FIFO between the input-control stage and the interpolation/calculation stage of the scaler. It stores the pixels that input control selects, one scaler line per buffer slot, in a ring of `LINE_NUM` slots. A slot is committed on each `jmp` pulse. It presents two vertically adjacent committed lines to the calculation stage at one shared x address with one-cycle read latency.

---
 rtl/line_buf_fifo.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/line_buf_fifo.sv
//==============================================================================
// Module  : line_buf_fifo
// Brief   : Line-buffer ring of LINE_NUM slots. Two line-interleaved banks
//           present lines n and n+1 at one shared x address.
// Option  : LINEBUF_ERR_FLAG_EN enables the sticky ovf/udf error flags.
// Revision: 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module line_buf_fifo #(
  parameter int DATA_WIDTH     = 24,
  parameter int ADDRESS_WIDTH  = 11,
  parameter int LINE_NUM       = 4,
  parameter int LINE_PTR_WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      rstN,
  input  logic                      iVsyn,
  input  logic                      ramWrtEn,
  input  logic [ADDRESS_WIDTH-1:0]  ramWrtAddr,
  input  logic [DATA_WIDTH-1:0]     dataIn,
  input  logic                      jmp,
  input  logic                      rdEn,
  input  logic [ADDRESS_WIDTH-1:0]  rdAddr,
  input  logic                      rdNxt,
  output logic [DATA_WIDTH-1:0]     dOutUp,
  output logic [DATA_WIDTH-1:0]     dOutDn,
  output logic                      dOutVld,
  output logic [ADDRESS_WIDTH:0]    rdLen,
  output logic [LINE_PTR_WIDTH:0]   lineCnt,
  output logic                      lineRdy,
  output logic                      full,
  output logic                      ovf,
  output logic                      udf
);

  localparam int c_ROW_W      = LINE_PTR_WIDTH - 1;
  localparam int c_BANK_AW    = c_ROW_W + ADDRESS_WIDTH;
  localparam int c_BANK_DEPTH = 1 << c_BANK_AW;

  localparam logic [LINE_PTR_WIDTH:0]   c_CNT_FULL = (LINE_PTR_WIDTH+1)'(LINE_NUM);
  localparam logic [LINE_PTR_WIDTH:0]   c_CNT_TWO  = (LINE_PTR_WIDTH+1)'(2);
  localparam logic [LINE_PTR_WIDTH:0]   c_CNT_ONE  = (LINE_PTR_WIDTH+1)'(1);
  localparam logic [LINE_PTR_WIDTH-1:0] c_PTR_ONE  = LINE_PTR_WIDTH'(1);
  localparam logic [ADDRESS_WIDTH:0]    c_LEN_ONE  = (ADDRESS_WIDTH+1)'(1);

  logic [LINE_PTR_WIDTH-1:0] r_wrLine;
  logic [LINE_PTR_WIDTH-1:0] r_rdLine;
  logic [LINE_PTR_WIDTH:0]   r_lineCnt;
  logic [ADDRESS_WIDTH:0]    r_curLen;
  logic [ADDRESS_WIDTH:0]    r_lenMem [LINE_NUM];
  logic                      r_dOutVld;
  logic                      r_upSel;

  logic                      w_full;
  logic                      w_lineRdy;
  logic                      w_wrAcc;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_rdAcc;
  logic [LINE_PTR_WIDTH-1:0] w_dnLine;
  logic [c_BANK_AW-1:0]      w_wrAddr;

  assign w_full    = (r_lineCnt == c_CNT_FULL);
  assign w_lineRdy = (r_lineCnt >= c_CNT_TWO);
  assign w_wrAcc   = ramWrtEn & ~w_full & ~iVsyn;
  assign w_push    = jmp & ~w_full & ~iVsyn;
  assign w_pop     = rdNxt & (r_lineCnt != '0) & ~iVsyn;
  assign w_rdAcc   = rdEn & w_lineRdy & ~iVsyn;
  assign w_dnLine  = r_rdLine + c_PTR_ONE;
  assign w_wrAddr  = {r_wrLine[LINE_PTR_WIDTH-1:1], ramWrtAddr};

  // Slot s lives in bank s[0], row s>>1, so lines n and n+1 never share a bank.
  genvar b;
  generate
    for (b = 0; b < 2; b++) begin : g_bank
      localparam logic c_BANK = 1'(b);
      logic [DATA_WIDTH-1:0] r_mem [c_BANK_DEPTH];
      logic [DATA_WIDTH-1:0] r_q;
      logic [c_BANK_AW-1:0]  w_rdAddr;

      assign w_rdAddr = (r_rdLine[0] == c_BANK) ?
                        {r_rdLine[LINE_PTR_WIDTH-1:1], rdAddr} :
                        {w_dnLine[LINE_PTR_WIDTH-1:1], rdAddr};

      always_ff @(posedge clk) begin
        if (w_wrAcc && (r_wrLine[0] == c_BANK)) begin
          r_mem[w_wrAddr] <= dataIn;
        end
      end

      always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
          r_q <= '0;
        end else if (w_rdAcc) begin
          r_q <= r_mem[w_rdAddr];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_wrLine  <= '0;
      r_rdLine  <= '0;
      r_lineCnt <= '0;
      r_curLen  <= '0;
      r_dOutVld <= 1'b0;
      r_upSel   <= 1'b0;
    end else if (iVsyn) begin
      r_wrLine  <= '0;
      r_rdLine  <= '0;
      r_lineCnt <= '0;
      r_curLen  <= '0;
      r_dOutVld <= 1'b0;
    end else begin
      r_dOutVld <= w_rdAcc;
      if (w_rdAcc) begin
        r_upSel <= r_rdLine[0];
      end
      if (w_push) begin
        r_wrLine <= r_wrLine + c_PTR_ONE;
        r_curLen <= '0;
      end else if (w_wrAcc) begin
        r_curLen <= {1'b0, ramWrtAddr} + c_LEN_ONE;
      end
      if (w_pop) begin
        r_rdLine <= r_rdLine + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_lineCnt <= r_lineCnt + c_CNT_ONE;
        2'b01:   r_lineCnt <= r_lineCnt - c_CNT_ONE;
        default: r_lineCnt <= r_lineCnt;
      endcase
    end
  end

  // Line lengths survive a frame clear; only reset empties them.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < LINE_NUM; i++) begin
        r_lenMem[i] <= '0;
      end
    end else if (w_push) begin
      r_lenMem[r_wrLine] <= r_curLen;
    end
  end

`ifdef LINEBUF_ERR_FLAG_EN
  logic r_ovf;
  logic r_udf;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else if (iVsyn) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if ((jmp || ramWrtEn) && w_full) begin
        r_ovf <= 1'b1;
      end
      if ((rdNxt && (r_lineCnt == '0)) || (rdEn && !w_lineRdy)) begin
        r_udf <= 1'b1;
      end
    end
  end

  assign ovf = r_ovf;
  assign udf = r_udf;
`else
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

  assign dOutUp  = r_upSel ? g_bank[1].r_q : g_bank[0].r_q;
  assign dOutDn  = r_upSel ? g_bank[0].r_q : g_bank[1].r_q;
  assign dOutVld = r_dOutVld;
  assign rdLen   = r_lenMem[r_rdLine];
  assign lineCnt = r_lineCnt;
  assign lineRdy = w_lineRdy;
  assign full    = w_full;

endmodule

`default_nettype wire
